read_from_cache: RTL and testbench
==================================

Name: read_from_cache

Overview:
- Read-side counterpart of the cache write path. Accepts a CPU read request carrying the one-hot hit way from tag compare, and pulses read-enable to that way's synchronous data array.
- Waits the array read latency, captures the selected way's word, and presents it to the CPU through a valid/ready response handshake.
- Sits between the tag-compare/controller logic and the per-way data arrays.

Parameters:
- NUM_WAYS, 4: number of ways; width of one-hot way select.
- DATA_WIDTH, 32: width of one cache data word.
- READ_LATENCY, 1: cycles from wayREn asserted to wayDataOut valid; legal range 1..7.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- reqValid  input  1  CPU read request valid.
- reqReady  output  1  block can accept a request.
- targetWay  input  NUM_WAYS  one-hot hit way; sampled on accept.
- wayREn  output  NUM_WAYS  per-way read enable, one-hot, single-cycle pulse.
- wayDataOut  input  NUM_WAYS*DATA_WIDTH  way i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- respValid  output  1  response data valid.
- respReady  input  1  CPU accepts response.
- respData  output  DATA_WIDTH  read word.
- respErr  output  1  request had zero or multiple ways set.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, counter 0, latched way 0. Outputs: reqReady=1, wayREn=0, respValid=0, respData=0, respErr=0.
- Reset mid-operation aborts: no wayREn, no response is issued.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - reqReady=1; accept when reqValid && reqReady (call this cycle 0). Latch targetWay.
  - If popcount(targetWay)==1, go to READ with counter cleared.
  - Otherwise go to RESP with respErr=1 and respData=0; no wayREn is ever issued for that request.
- READ:
  - reqReady=0.
  - Cycle 1: wayREn = latched way. wayREn is 0 in all other cycles.
  - Counter increments every cycle. In cycle 1+READ_LATENCY, capture the selected slice of wayDataOut into respData (one-hot AND-OR select), set respErr=0, go to RESP.
- RESP:
  - respValid=1 (first asserted in cycle 2+READ_LATENCY for valid requests, cycle 1 for error requests).
  - respData and respErr are held stable while respValid && !respReady.
  - On respValid && respReady, go to IDLE; respValid drops next cycle, and respData/respErr retain their last values.
- No same-cycle turnaround: reqReady is 0 in the cycle of the response handshake. At most one request is outstanding.
- wayDataOut is ignored outside the capture cycle. Way data changing at any other time has no effect.

Optional Feature:
- Macro: READ_FROM_CACHE_PARITY_EN.
- Defined:
  - Adds input wayParity (NUM_WAYS, even parity per way word) and output respParityErr.
  - In the capture cycle, respParityErr = (^selected word) ^ wayParity[way].
  - respParityErr is held with respData, reset to 0, and forced to 0 on error responses.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- cache_pkg holds:
  - the state enum (IDLE, READ, RESP);
  - default NUM_WAYS/DATA_WIDTH constants;
  - function is_onehot(logic [NUM_WAYS-1:0]).
- Sub-module way_select_mux, a parameterised one-hot AND-OR selector of a DATA_WIDTH slice, instantiated once.

Test Plan:
- Reset then idle, READ_LATENCY=1 -> reqReady=1, wayREn=0, respValid=0, respData=0.
- Accept targetWay=4'b0100, way2 word 0xDEADBEEF, READ_LATENCY=1 -> wayREn=4'b0100 in cycle 1 only; respValid in cycle 3 with respData=0xDEADBEEF, respErr=0.
- targetWay=4'b0110, then a separate request with targetWay=4'b0000 -> each gives respValid in cycle 1 with respErr=1, respData=0, and wayREn never asserted.
- Valid read of way0=0x12345678 with respReady held 0 for 5 cycles, other ways' data toggling -> respData stays 0x12345678; reqReady=0 throughout; one handshake returns to IDLE.
- rst_n low during READ at cycle 1 -> next cycle IDLE, respValid never asserts; a following read of way3=0x0000A5A5 completes normally.
- With READ_FROM_CACHE_PARITY_EN, read of 0x00000001 with wayParity bit 0 -> respParityErr=1; with parity bit 1 -> respParityErr=0.

Source files
------------

// File: rtl/read_from_cache_pkg.sv
// Shared types and defaults for the cache read path.
// Holds the read FSM state enum and the one-hot check helper.
package cache_pkg;

    localparam int DEF_NUM_WAYS   = 4;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_e;

    function automatic logic is_onehot(input logic [DEF_NUM_WAYS-1:0] v);
        return $countones(v) == 1;
    endfunction

endpackage

// File: rtl/read_from_cache_if.sv
// CPU-side request/response handshake bundle of the cache read path.
// Optional READ_FROM_CACHE_PARITY_EN adds respParityErr.
interface read_from_cache_if
    import cache_pkg::*;
#(
    parameter int NUM_WAYS   = DEF_NUM_WAYS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  reqValid;
    logic                  reqReady;
    logic [NUM_WAYS-1:0]   targetWay;
    logic                  respValid;
    logic                  respReady;
    logic [DATA_WIDTH-1:0] respData;
    logic                  respErr;
`ifdef READ_FROM_CACHE_PARITY_EN
    logic                  respParityErr;

    modport master (
        output reqValid, targetWay, respReady,
        input  reqReady, respValid, respData, respErr, respParityErr
    );

    modport slave (
        input  reqValid, targetWay, respReady,
        output reqReady, respValid, respData, respErr, respParityErr
    );
`else
    modport master (
        output reqValid, targetWay, respReady,
        input  reqReady, respValid, respData, respErr
    );

    modport slave (
        input  reqValid, targetWay, respReady,
        output reqReady, respValid, respData, respErr
    );
`endif

endinterface

// File: rtl/read_from_cache_mux.sv
// One-hot AND-OR selector of one DATA_WIDTH slice out of NUM_WAYS words.
module way_select_mux #(
    parameter int NUM_WAYS   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [NUM_WAYS-1:0]            sel_i,
    input  logic [NUM_WAYS*DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0]          data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            data_o = data_o | (data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_i[i]}});
        end
    end

endmodule

// File: rtl/read_from_cache.sv
// Cache read path: pulses one way's read enable, waits the array latency,
// returns the word over valid/ready. Option: READ_FROM_CACHE_PARITY_EN.
module read_from_cache
    import cache_pkg::*;
#(
    parameter int NUM_WAYS     = DEF_NUM_WAYS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    read_from_cache_if.slave               cpu,
    output logic [NUM_WAYS-1:0]            wayREn,
    input  logic [NUM_WAYS*DATA_WIDTH-1:0] wayDataOut
`ifdef READ_FROM_CACHE_PARITY_EN
    ,
    input  logic [NUM_WAYS-1:0]            wayParity
`endif
);

    localparam int             CW  = 3;
    localparam logic [CW-1:0]  LAT = CW'(READ_LATENCY);

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [NUM_WAYS-1:0]   way_q;
    logic [NUM_WAYS-1:0]   wren_q;
    logic                  req_rdy_q;
    logic                  resp_vld_q;
    logic                  resp_err_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  par_err_d;

    way_select_mux #(
        .NUM_WAYS   (NUM_WAYS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .sel_i  (way_q),
        .data_i (wayDataOut),
        .data_o (sel_data)
    );

`ifdef READ_FROM_CACHE_PARITY_EN
    logic par_err_q;
    assign par_err_d         = (^sel_data) ^ (|(wayParity & way_q));
    assign cpu.respParityErr = par_err_q;
`else
    assign par_err_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            way_q       <= '0;
            wren_q      <= '0;
            req_rdy_q   <= 1'b1;
            resp_vld_q  <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
`ifdef READ_FROM_CACHE_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            wren_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (cpu.reqValid && req_rdy_q) begin
                        way_q     <= cpu.targetWay;
                        cnt_q     <= '0;
                        req_rdy_q <= 1'b0;
                        if (is_onehot(cpu.targetWay)) begin
                            state_q <= READ;
                            wren_q  <= cpu.targetWay;
                        end else begin
                            // Bad way select: answer immediately, never touch the arrays
                            state_q     <= RESP;
                            resp_vld_q  <= 1'b1;
                            resp_err_q  <= 1'b1;
                            resp_data_q <= '0;
`ifdef READ_FROM_CACHE_PARITY_EN
                            par_err_q   <= 1'b0;
`endif
                        end
                    end
                end
                READ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAT) begin
                        state_q     <= RESP;
                        resp_vld_q  <= 1'b1;
                        resp_err_q  <= 1'b0;
                        resp_data_q <= sel_data;
`ifdef READ_FROM_CACHE_PARITY_EN
                        par_err_q   <= par_err_d;
`endif
                    end
                end
                RESP: begin
                    if (cpu.respReady) begin
                        state_q    <= IDLE;
                        resp_vld_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu.reqReady  = req_rdy_q;
    assign cpu.respValid = resp_vld_q;
    assign cpu.respData  = resp_data_q;
    assign cpu.respErr   = resp_err_q;
    assign wayREn        = wren_q;

    logic unused_par;
    assign unused_par = par_err_d;

endmodule

// File: tb/tb_read_from_cache.sv
// Scoreboard bench for read_from_cache: stimulus pushes expected responses,
// a negedge monitor pops and checks them along with wayREn timing.
module tb_read_from_cache;
    import cache_pkg::*;

    localparam int NW  = 4;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    read_from_cache_if #(.NUM_WAYS(NW), .DATA_WIDTH(DW)) cpu();
    logic [NW-1:0]    wayREn;
    logic [NW*DW-1:0] wayDataOut;
`ifdef READ_FROM_CACHE_PARITY_EN
    logic [NW-1:0]    wayParity;
`endif

    read_from_cache #(
        .NUM_WAYS     (NW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu        (cpu),
        .wayREn     (wayREn),
        .wayDataOut (wayDataOut)
`ifdef READ_FROM_CACHE_PARITY_EN
        ,
        .wayParity  (wayParity)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          perr;
        int            first;
    } exp_t;

    exp_t          sb[$];
    int            total   = 0;
    int            bad     = 0;
    int            cyc     = 0;
    int            ren_cyc = -1;
    logic [NW-1:0] ren_way = '0;
    logic [NW-1:0] exp_ren;
    bit            mon_en  = 0;
    bit            prev_v  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_ren = (cyc == ren_cyc) ? ren_way : '0;
            check("wayREn", 64'(wayREn), 64'(exp_ren));
            if (cpu.respValid) begin
                check("reqReady_busy", 64'(cpu.reqReady), 64'd0);
                if (sb.size() == 0) begin
                    check("spurious_resp", 64'(cpu.respValid), 64'd0);
                end else begin
                    check("respData", 64'(cpu.respData), 64'(sb[0].data));
                    check("respErr", 64'(cpu.respErr), 64'(sb[0].err));
`ifdef READ_FROM_CACHE_PARITY_EN
                    check("respParityErr", 64'(cpu.respParityErr), 64'(sb[0].perr));
`endif
                    if (!prev_v) check("first_valid_cycle", 64'(cyc), 64'(sb[0].first));
                    if (cpu.respReady) void'(sb.pop_front());
                end
            end
            prev_v = cpu.respValid;
        end
    end

    task automatic set_way(input int i, input logic [DW-1:0] v);
        wayDataOut[i*DW +: DW] = v;
    endtask

    task automatic issue(input logic [NW-1:0] way, input logic [DW-1:0] d,
                         input logic err, input logic perr);
        exp_t e;
        int   n = 0;
        while (!cpu.reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reqReady_idle", 64'(cpu.reqReady), 64'd1);
        e.data  = d;
        e.err   = err;
        e.perr  = perr;
        e.first = cyc + (err ? 1 : 2 + LAT);
        sb.push_back(e);
        ren_cyc = cyc + 1;
        ren_way = err ? '0 : way;
        cpu.reqValid  = 1'b1;
        cpu.targetWay = way;
        @(posedge clk);
        #1;
        cpu.reqValid  = 1'b0;
        cpu.targetWay = '0;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !cpu.reqReady) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n;
        cpu.reqValid  = 1'b0;
        cpu.targetWay = '0;
        cpu.respReady = 1'b1;
        wayDataOut    = '0;
`ifdef READ_FROM_CACHE_PARITY_EN
        wayParity     = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_reqReady", 64'(cpu.reqReady), 64'd1);
        check("rst_wayREn", 64'(wayREn), 64'd0);
        check("rst_respValid", 64'(cpu.respValid), 64'd0);
        check("rst_respData", 64'(cpu.respData), 64'd0);
        check("rst_respErr", 64'(cpu.respErr), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1;
        @(negedge clk);

        set_way(0, 32'h1111_1111);
        set_way(1, 32'h2222_2222);
        set_way(2, 32'hDEAD_BEEF);
        set_way(3, 32'h4444_4444);
        issue(4'b0100, 32'hDEAD_BEEF, 1'b0, 1'b0);
        wait_done();
        check("retain_data", 64'(cpu.respData), 64'hDEAD_BEEF);
        check("retain_valid_low", 64'(cpu.respValid), 64'd0);

        issue(4'b0110, 32'h0, 1'b1, 1'b0);
        wait_done();
        issue(4'b0000, 32'h0, 1'b1, 1'b0);
        wait_done();

        set_way(0, 32'h1234_5678);
        cpu.respReady = 1'b0;
        issue(4'b0001, 32'h1234_5678, 1'b0, 1'b0);
        n = 0;
        while (!cpu.respValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", 64'(cpu.respValid), 64'd1);
        repeat (5) begin
            wayDataOut = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        cpu.respReady = 1'b1;
        wait_done();

        set_way(1, 32'h0BAD_F00D);
        ren_cyc = cyc + 1;
        ren_way = 4'b0010;
        cpu.reqValid  = 1'b1;
        cpu.targetWay = 4'b0010;
        @(posedge clk);
        #1;
        cpu.reqValid  = 1'b0;
        cpu.targetWay = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_reqReady", 64'(cpu.reqReady), 64'd1);
        check("abort_respValid", 64'(cpu.respValid), 64'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        set_way(3, 32'h0000_A5A5);
        issue(4'b1000, 32'h0000_A5A5, 1'b0, 1'b0);
        wait_done();

        set_way(1, 32'hCAFE_0001);
        issue(4'b0010, 32'hCAFE_0001, 1'b0, 1'b0);
        wait_done();

`ifdef READ_FROM_CACHE_PARITY_EN
        set_way(0, 32'h0000_0001);
        wayParity = 4'b0000;
        issue(4'b0001, 32'h0000_0001, 1'b0, 1'b1);
        wait_done();
        wayParity = 4'b0001;
        issue(4'b0001, 32'h0000_0001, 1'b0, 1'b0);
        wait_done();
        issue(4'b1111, 32'h0, 1'b1, 1'b0);
        wait_done();
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
